squeeze_dump_unit: RTL and testbench

//  Parametrised output stage of the SHAKE core: buffers squeezed rate blocks from the permutation

---
 rtl/keccak_pkg.sv | 10 +
 rtl/block_fifo.sv | 48 ++++
 rtl/squeeze_dump_unit.sv | 107 ++++++++++
 tb/tb_squeeze_dump_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// keccak_pkg: shared SHAKE rate constants, mode encoding and block/word helpers
package keccak_pkg;
  localparam int RATE_SHAKE128 = 1344;
  localparam int RATE_SHAKE256 = 1088;
  localparam int RATE_MAX = RATE_SHAKE128;
  typedef enum logic {SHAKE128 = 1'b0, SHAKE256 = 1'b1} shake_mode_t;
  function automatic int words_per_block(input int rate, input int w);
    return rate / w;
  endfunction
endpackage

// File: rtl/block_fifo.sv
// block_fifo: DEPTH-entry FIFO of whole rate blocks with async reset and sync clear
module block_fifo #(
  parameter int WIDTH = 1344,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd_ptr];
  // block storage needs no reset; occupancy is tracked by count alone
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // pointers wrap modulo DEPTH; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/squeeze_dump_unit.sv
// squeeze_dump_unit: buffers squeezed rate blocks and streams them as truncated W-bit words
module squeeze_dump_unit
  import keccak_pkg::*;
#(
  parameter int W = 64,
  parameter int DEPTH = 2,
  parameter int SIZE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                start,
  input  logic                mode,
  input  logic [SIZE_W-1:0]   output_size,
  input  logic [RATE_MAX-1:0] block_data,
  input  logic                block_valid,
  output logic                block_ready,
  output logic [W-1:0]        data_out,
  output logic [W/8-1:0]      keep_out,
  output logic                valid_out,
  output logic                last_out,
  input  logic                ready_in,
  output logic                busy,
  output logic                done
);
  localparam int WI_W = $clog2(RATE_MAX / W + 1);
  localparam int LOW_W = $clog2(W) + 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state;
  shake_mode_t sel_mode;
  logic [SIZE_W-1:0] rem_bits, blocks_needed, blocks_accepted;
  logic [WI_W-1:0] word_idx, wpb;
  logic [RATE_MAX-1:0] head;
  logic full, empty, push, pop, hs, last_int;
  logic [LOW_W-1:0] low_bits;
  logic [W-1:0] bit_mask;
  function automatic logic [SIZE_W-1:0] blocks_for(input logic [SIZE_W-1:0] bits, input int rate);
    return bits / SIZE_W'(rate) + SIZE_W'(bits % SIZE_W'(rate) != '0);
  endfunction
  assign sel_mode = shake_mode_t'(mode);
  assign valid_out = state == S_RUN && !empty;
  assign last_int = rem_bits <= SIZE_W'(W);
  assign low_bits = last_int ? LOW_W'(rem_bits) : LOW_W'(W);
  assign bit_mask = ~({W{1'b1}} << low_bits);
  assign data_out = valid_out ? head[int'(word_idx) * W +: W] & bit_mask : '0;
  assign last_out = valid_out && last_int;
  assign hs = valid_out && ready_in;
  assign pop = hs && (word_idx == wpb - 1'b1 || last_int);
  assign block_ready = state == S_RUN && !full && blocks_accepted < blocks_needed;
  assign push = block_valid && block_ready;
  assign busy = state == S_RUN;
  assign done = state == S_DONE;
  // a byte is kept when its lowest bit survives truncation
  always_comb begin
    keep_out = '0;
    for (int i = 0; i < W / 8; i++) keep_out[i] = valid_out && bit_mask[8 * i];
  end
  block_fifo #(.WIDTH(RATE_MAX), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clear(flush),
    .push(push),
    .pop(pop),
    .din(block_data),
    .head(head),
    .full(full),
    .empty(empty)
  );
  // message FSM with length, block and word bookkeeping; flush aborts everything
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      rem_bits <= '0;
      blocks_needed <= '0;
      blocks_accepted <= '0;
      word_idx <= '0;
      wpb <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      rem_bits <= '0;
      blocks_needed <= '0;
      blocks_accepted <= '0;
      word_idx <= '0;
      wpb <= '0;
    end else
      case (state)
        S_IDLE:
          if (start) begin
            rem_bits <= output_size;
            blocks_accepted <= '0;
            word_idx <= '0;
            blocks_needed <= sel_mode == SHAKE256 ? blocks_for(output_size, RATE_SHAKE256)
                                                  : blocks_for(output_size, RATE_SHAKE128);
            wpb <= WI_W'(words_per_block(sel_mode == SHAKE256 ? RATE_SHAKE256 : RATE_SHAKE128, W));
            state <= output_size == '0 ? S_DONE : S_RUN;
          end
        S_RUN: begin
          if (push) blocks_accepted <= blocks_accepted + 1'b1;
          if (hs) begin
            rem_bits <= last_int ? '0 : rem_bits - SIZE_W'(W);
            word_idx <= pop ? '0 : word_idx + 1'b1;
            if (last_int) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_squeeze_dump_unit.sv
// tb_squeeze_dump_unit: directed tests with a per-cycle reference model for W=64 and W=32 units
module tb_squeeze_dump_unit;
  import keccak_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst, flush, start, mode, ready_in;
  logic [31:0] output_size;
  logic [RATE_MAX-1:0] blk [8];
  logic [3:0] src_idx [2];
  logic bv0, bv1, br0, br1, v0, v1, l0, l1, bz0, bz1, dn0, dn1;
  logic [63:0] d0;
  logic [31:0] d1;
  logic [7:0] k0;
  logic [3:0] k1;
  int errors = 0, checks = 0;
  int kw[2], pushed[2], hs[2], vcnt[2];
  bit active[2], done_e[2], stall[2], got_done[2];
  logic [63:0] pd[2];
  logic [7:0] pk[2];
  logic pl[2];
  logic [63:0] obs_d[2][256];
  logic [7:0] obs_k[2][256];
  logic obs_l[2][256];
  int m_size = 0;
  bit m_mode = 1'b0;
  logic [63:0] tmp;

  always #5 clk = ~clk;

  assign bv0 = src_idx[0] < 4'd8;
  assign bv1 = src_idx[1] < 4'd8;

  squeeze_dump_unit #(.W(64), .DEPTH(DEPTH), .SIZE_W(32)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .mode(mode), .output_size(output_size),
    .block_data(blk[src_idx[0][2:0]]), .block_valid(bv0), .block_ready(br0),
    .data_out(d0), .keep_out(k0), .valid_out(v0), .last_out(l0), .ready_in(ready_in),
    .busy(bz0), .done(dn0)
  );

  squeeze_dump_unit #(.W(32), .DEPTH(DEPTH), .SIZE_W(32)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .mode(mode), .output_size(output_size),
    .block_data(blk[src_idx[1][2:0]]), .block_valid(bv1), .block_ready(br1),
    .data_out(d1), .keep_out(k1), .valid_out(v1), .last_out(l1), .ready_in(ready_in),
    .busy(bz1), .done(dn1)
  );

  // block source: each unit is offered blk[0], blk[1], ... in order per message
  always @(posedge clk) begin
    if (start) begin
      src_idx[0] <= 4'd0;
      src_idx[1] <= 4'd0;
    end else begin
      if (bv0 && br0) src_idx[0] <= src_idx[0] + 4'd1;
      if (bv1 && br1) src_idx[1] <= src_idx[1] + 4'd1;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model for one unit, evaluated once per cycle away from the clock edge
  task automatic mon(input int i, input int w, input logic [63:0] d, input logic [7:0] k,
                     input logic v, input logic l, input logic br, input logic bv,
                     input logic bz, input logic dn);
    string nm;
    int rate, wpb, need, total, occ, rem, b, off;
    bit was_done, was_active;
    logic [63:0] ed;
    logic [7:0] ek;
    nm = i == 0 ? "u64" : "u32";
    rate = m_mode ? 1088 : 1344;
    wpb = rate / w;
    need = (m_size + rate - 1) / rate;
    total = (m_size + w - 1) / w;
    occ = pushed[i] - kw[i] / wpb;
    was_done = done_e[i];
    was_active = active[i];
    if (!rst) begin
      check({nm, " reset_ctl"}, {59'd0, v, l, bz, dn, br}, 64'd0);
      check({nm, " reset_data"}, d | {56'd0, k}, 64'd0);
      active[i] = 0;
      done_e[i] = 0;
      stall[i] = 0;
      return;
    end
    check({nm, " valid"}, v, active[i] && occ > 0);
    check({nm, " block_ready"}, br, active[i] && occ < DEPTH && pushed[i] < need);
    check({nm, " busy"}, bz, active[i]);
    check({nm, " done"}, dn, done_e[i]);
    if (active[i] && v) begin
      rem = m_size - kw[i] * w;
      b = kw[i] / wpb;
      off = (kw[i] % wpb) * w;
      ed = '0;
      ek = '0;
      for (int j = 0; j < w; j++) if (j < rem) ed[j] = blk[b][off + j];
      for (int j = 0; j < w / 8; j++) ek[j] = 8 * j < rem;
      check({nm, " data"}, d, ed);
      check({nm, " keep"}, k, ek);
      check({nm, " last"}, l, rem <= w);
    end else if (!active[i])
      check({nm, " idle_out"}, d | {55'd0, k, l}, 64'd0);
    if (stall[i]) check({nm, " stable"}, {v, l, k, d[53:0]}, {1'b1, pl[i], pk[i], pd[i][53:0]});
    if (dn) got_done[i] = 1;
    if (v) vcnt[i]++;
    stall[i] = v && !ready_in;
    pd[i] = d;
    pk[i] = k;
    pl[i] = l;
    done_e[i] = 0;
    if (flush) begin
      active[i] = 0;
      stall[i] = 0;
      return;
    end
    if (bv && br) pushed[i]++;
    if (v && ready_in && was_active) begin
      obs_d[i][kw[i]] = d;
      obs_k[i][kw[i]] = k;
      obs_l[i][kw[i]] = l;
      kw[i]++;
      hs[i]++;
      if (kw[i] == total) begin
        active[i] = 0;
        done_e[i] = 1;
        stall[i] = 0;
      end
    end
    if (start && !was_active && !was_done) begin
      kw[i] = 0;
      pushed[i] = 0;
      hs[i] = 0;
      vcnt[i] = 0;
      active[i] = output_size != 0;
      done_e[i] = output_size == 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst && start && !active[0] && !done_e[0]) begin
      m_size = int'(output_size);
      m_mode = mode;
    end
    mon(0, 64, d0, k0, v0, l0, br0, bv0, bz0, dn0);
    mon(1, 32, {32'd0, d1}, {4'd0, k1}, v1, l1, br1, bv1, bz1, dn1);
  end

  task automatic run_msg(input bit md, input int sz);
    got_done[0] = 0;
    got_done[1] = 0;
    mode = md;
    output_size = sz;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    mode = ~md;
    output_size = 32'hFFFF_FFFF;
  endtask

  task automatic wait_done(input bit rnd);
    int n = 0;
    while (!(got_done[0] && got_done[1]) && n < 3000) begin
      @(posedge clk);
      #1;
      if (rnd) ready_in = $urandom_range(0, 3) != 0;
      n++;
    end
    check("wait_done_timeout", n < 3000, 1);
    ready_in = 1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 0;
    flush = 0;
    start = 0;
    mode = 0;
    output_size = 0;
    ready_in = 1;
    src_idx[0] = 0;
    src_idx[1] = 0;
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < RATE_MAX / 32; j++) blk[b][j * 32 +: 32] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid_busy", {v0, bz0, br0, dn0, l0, v1}, 6'd0);
    rst = 1;
    @(posedge clk);
    #1;
    // 1: SHAKE128, 256 bits
    run_msg(0, 256);
    wait_done(0);
    check("t1_words64", hs[0], 4);
    check("t1_words32", hs[1], 8);
    check("t1_blocks", pushed[0], 1);
    check("t1_keep3", obs_k[0][3], 8'hFF);
    check("t1_last", {obs_l[0][2], obs_l[0][3]}, 2'b01);
    check("t1_word0", obs_d[0][0], blk[0][63:0]);
    // 2: SHAKE256, two full blocks, random backpressure
    run_msg(1, 2176);
    wait_done(1);
    check("t2_words64", hs[0], 34);
    check("t2_words32", hs[1], 68);
    check("t2_blocks", pushed[0], 2);
    check("t2_word17", obs_d[0][17], blk[1][63:0]);
    check("t2_word34_w32", obs_d[1][34], {32'd0, blk[1][31:0]});
    // 3: SHAKE128, 100 bits, partial final byte
    run_msg(0, 100);
    wait_done(0);
    check("t3_words32", hs[1], 4);
    check("t3_keep3_w32", obs_k[1][3], 8'h01);
    check("t3_data3_w32", obs_d[1][3], {60'd0, blk[0][99:96]});
    check("t3_last3_w32", obs_l[1][3], 1);
    check("t3_words64", hs[0], 2);
    check("t3_keep1", obs_k[0][1], 8'h1F);
    tmp = blk[0][127:64];
    tmp[63:36] = '0;
    check("t3_data1", obs_d[0][1], tmp);
    // 4: backpressure with a full FIFO, three blocks needed
    ready_in = 0;
    run_msg(0, 4032);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("t4_held_blocks64", pushed[0], 2);
    check("t4_held_blocks32", pushed[1], 2);
    check("t4_full_ready", {br0, br1}, 2'b00);
    check("t4_valid_held", {v0, v1}, 2'b11);
    @(posedge clk);
    #1 ready_in = 1;
    wait_done(0);
    check("t4_blocks", pushed[0], 3);
    check("t4_words64", hs[0], 63);
    // 5: zero-length request
    run_msg(0, 0);
    wait_done(0);
    check("t5_no_words", hs[0] + hs[1], 0);
    check("t5_no_valid", vcnt[0] + vcnt[1], 0);
    check("t5_no_blocks", pushed[0] + pushed[1], 0);
    // 6: flush at word 5 of 21, clean restart, then async reset mid-message
    run_msg(0, 1344);
    n = 0;
    while (hs[0] < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_word5", n < 200, 1);
    @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    check("t6_flush_out", {v0, bz0, br0, l0, v1, bz1}, 6'd0);
    @(posedge clk);
    #1;
    run_msg(0, 1344);
    wait_done(1);
    check("t6_words64", hs[0], 21);
    check("t6_words32", hs[1], 42);
    run_msg(1, 2184);
    repeat (6) @(posedge clk);
    #2 rst = 0;
    #1;
    check("t6_rst_ctl", {v0, bz0, br0, dn0, l0, v1, bz1, br1}, 8'd0);
    check("t6_rst_data", d0 | {32'd0, d1} | {56'd0, k0}, 64'd0);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1;
    run_msg(1, 1096);
    wait_done(1);
    check("t6_words_after", hs[0], 18);
    check("t6_keep_last", obs_k[0][17], 8'h01);
    check("t6_last_data", obs_d[0][17], {56'd0, blk[1][7:0]});
    check("t6_keep_last_w32", obs_k[1][34], 8'h01);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
